// File: rtl/sram_1rw_rr_arbiter.sv
// Purpose: shares one 1rw SRAM between two val/rdy clients with round-robin arbitration, one transaction in flight.
// Latency: read accepted at t -> resp_val at t+2; write accepted at t -> zero-data ack at t+1.
// Backpressure: requests are accepted only in IDLE; the response is held in a buffer until the owner's resp_rdy.
// Optional feature macro: SRAM_ARB_GRANT_CNT_EN (saturating 16-bit per-port grant counters).
module sram_1rw_rr_arbiter #(
    parameter int  p_data_nbits  = 32,
    parameter int  p_num_entries = 256,
    localparam int c_addr_nbits  = $clog2(p_num_entries),
    localparam int c_data_nbytes = (p_data_nbits + 7) / 8
) (
    input  logic                     clk,
    input  logic                     reset,

    input  logic                     req0_val,
    output logic                     req0_rdy,
    input  logic                     req0_type,
    input  logic [c_addr_nbits-1:0]  req0_addr,
    input  logic [p_data_nbits-1:0]  req0_data,
    input  logic [c_data_nbytes-1:0] req0_byte_en,

    input  logic                     req1_val,
    output logic                     req1_rdy,
    input  logic                     req1_type,
    input  logic [c_addr_nbits-1:0]  req1_addr,
    input  logic [p_data_nbits-1:0]  req1_data,
    input  logic [c_data_nbytes-1:0] req1_byte_en,

    output logic                     resp0_val,
    input  logic                     resp0_rdy,
    output logic [p_data_nbits-1:0]  resp0_data,

    output logic                     resp1_val,
    input  logic                     resp1_rdy,
    output logic [p_data_nbits-1:0]  resp1_data,

    output logic                     sram_read_en,
    output logic [c_addr_nbits-1:0]  sram_read_addr,
    input  logic [p_data_nbits-1:0]  sram_read_data,
    output logic                     sram_write_en,
    output logic [c_data_nbytes-1:0] sram_write_byte_en,
    output logic [c_addr_nbits-1:0]  sram_write_addr,
    output logic [p_data_nbits-1:0]  sram_write_data,

    output logic [15:0]              grant_cnt0,
    output logic [15:0]              grant_cnt1
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_WAIT = 2'd1,
        ST_RESP    = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic                      prio_q, prio_d;     // port that wins if both are valid
    logic                      owner_q, owner_d;   // port owning the in-flight transaction
    logic [p_data_nbits-1:0]   resp_buf_q, resp_buf_d;

    logic                      gnt0, gnt1, any_gnt;
    logic                      sel_type;
    logic [c_addr_nbits-1:0]   sel_addr;
    logic [p_data_nbits-1:0]   sel_data;
    logic [c_data_nbytes-1:0]  sel_byte_en;
    logic                      resp_active;
    logic                      owner_rdy;

    // Arbitration: grants only in IDLE and never while reset is held, so all outputs read 0 during reset.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (state_q == ST_IDLE && !reset) begin
            gnt0 = req0_val && (!prio_q || !req1_val);
            gnt1 = req1_val && ( prio_q || !req0_val);
        end
        any_gnt     = gnt0 | gnt1;
        sel_type    = gnt1 ? req1_type    : req0_type;
        sel_addr    = gnt1 ? req1_addr    : req0_addr;
        sel_data    = gnt1 ? req1_data    : req0_data;
        sel_byte_en = gnt1 ? req1_byte_en : req0_byte_en;
        req0_rdy    = gnt0;
        req1_rdy    = gnt1;
    end

    // SRAM access is issued in the grant cycle itself; address/data buses are zeroed when idle.
    always_comb begin
        sram_read_en       = 1'b0;
        sram_read_addr     = '0;
        sram_write_en      = 1'b0;
        sram_write_addr    = '0;
        sram_write_data    = '0;
        sram_write_byte_en = '0;
        if (any_gnt) begin
            if (sel_type) begin
                sram_write_en      = 1'b1;
                sram_write_addr    = sel_addr;
                sram_write_data    = sel_data;
                sram_write_byte_en = sel_byte_en;
            end else begin
                sram_read_en   = 1'b1;
                sram_read_addr = sel_addr;
            end
        end
    end

    // Response presentation: only the owner sees resp_val, data reads 0 whenever not valid.
    always_comb begin
        resp_active = (state_q == ST_RESP) && !reset;
        resp0_val   = resp_active && !owner_q;
        resp1_val   = resp_active &&  owner_q;
        resp0_data  = resp0_val ? resp_buf_q : '0;
        resp1_data  = resp1_val ? resp_buf_q : '0;
        owner_rdy   = owner_q ? resp1_rdy : resp0_rdy;
    end

    // Next-state logic: priority flips to the other port after every grant; resp_rdy only matters in RESP.
    always_comb begin
        state_d    = state_q;
        prio_d     = prio_q;
        owner_d    = owner_q;
        resp_buf_d = resp_buf_q;
        case (state_q)
            ST_IDLE: begin
                if (any_gnt) begin
                    owner_d = gnt1;
                    prio_d  = ~gnt1;
                    if (sel_type) begin
                        resp_buf_d = '0;
                        state_d    = ST_RESP;
                    end else begin
                        state_d = ST_RD_WAIT;
                    end
                end
            end
            ST_RD_WAIT: begin
                resp_buf_d = sram_read_data;
                state_d    = ST_RESP;
            end
            ST_RESP: begin
                if (owner_rdy) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM and datapath registers; reset drops any in-flight transaction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            prio_q     <= 1'b0;
            owner_q    <= 1'b0;
            resp_buf_q <= '0;
        end else begin
            state_q    <= state_d;
            prio_q     <= prio_d;
            owner_q    <= owner_d;
            resp_buf_q <= resp_buf_d;
        end
    end

`ifdef SRAM_ARB_GRANT_CNT_EN
    logic [15:0] grant_cnt0_q, grant_cnt0_d;
    logic [15:0] grant_cnt1_q, grant_cnt1_d;

    // Saturating grant counters, one per port.
    always_comb begin
        grant_cnt0_d = grant_cnt0_q;
        grant_cnt1_d = grant_cnt1_q;
        if (gnt0 && grant_cnt0_q != 16'hFFFF) grant_cnt0_d = grant_cnt0_q + 16'd1;
        if (gnt1 && grant_cnt1_q != 16'hFFFF) grant_cnt1_d = grant_cnt1_q + 16'd1;
    end

    // Counter registers, cleared by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant_cnt0_q <= '0;
            grant_cnt1_q <= '0;
        end else begin
            grant_cnt0_q <= grant_cnt0_d;
            grant_cnt1_q <= grant_cnt1_d;
        end
    end

    assign grant_cnt0 = grant_cnt0_q;
    assign grant_cnt1 = grant_cnt1_q;
`else
    assign grant_cnt0 = '0;
    assign grant_cnt1 = '0;
`endif

endmodule

// File: tb/tb_sram_1rw_rr_arbiter.sv
// Bench for sram_1rw_rr_arbiter: random and directed traffic on both ports against a memory/arbiter reference model.
// Accepted requests push expected responses; a response monitor pops and compares data and latency.
// The SRAM itself is a behavioural array with one-cycle read latency.
module tb_sram_1rw_rr_arbiter;
    localparam int DW = 32;
    localparam int NE = 256;
    localparam int AW = 8;
    localparam int BW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0_val, req0_rdy, req0_type;
    logic [AW-1:0] req0_addr;
    logic [DW-1:0] req0_data;
    logic [BW-1:0] req0_byte_en;
    logic          req1_val, req1_rdy, req1_type;
    logic [AW-1:0] req1_addr;
    logic [DW-1:0] req1_data;
    logic [BW-1:0] req1_byte_en;
    logic          resp0_val, resp0_rdy, resp1_val, resp1_rdy;
    logic [DW-1:0] resp0_data, resp1_data;
    logic          sram_read_en, sram_write_en;
    logic [AW-1:0] sram_read_addr, sram_write_addr;
    logic [DW-1:0] sram_read_data, sram_write_data;
    logic [BW-1:0] sram_write_byte_en;
    logic [15:0]   grant_cnt0, grant_cnt1;

    always #5 clk = ~clk;

    sram_1rw_rr_arbiter #(.p_data_nbits(DW), .p_num_entries(NE)) dut (
        .clk(clk), .reset(rst),
        .req0_val(req0_val), .req0_rdy(req0_rdy), .req0_type(req0_type), .req0_addr(req0_addr),
        .req0_data(req0_data), .req0_byte_en(req0_byte_en),
        .req1_val(req1_val), .req1_rdy(req1_rdy), .req1_type(req1_type), .req1_addr(req1_addr),
        .req1_data(req1_data), .req1_byte_en(req1_byte_en),
        .resp0_val(resp0_val), .resp0_rdy(resp0_rdy), .resp0_data(resp0_data),
        .resp1_val(resp1_val), .resp1_rdy(resp1_rdy), .resp1_data(resp1_data),
        .sram_read_en(sram_read_en), .sram_read_addr(sram_read_addr), .sram_read_data(sram_read_data),
        .sram_write_en(sram_write_en), .sram_write_byte_en(sram_write_byte_en),
        .sram_write_addr(sram_write_addr), .sram_write_data(sram_write_data),
        .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] init_word(input int i);
        return 32'(i) * 32'h9E3779B1;
    endfunction

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                            input logic [BW-1:0] be);
        logic [DW-1:0] r;
        r = old;
        for (int b = 0; b < BW; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    // Behavioural SRAM: synchronous byte-masked write, read data valid the cycle after read_en.
    logic          mem_init;
    logic [DW-1:0] sram_mem [NE];
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < NE; i++) sram_mem[i] <= init_word(i);
        end else begin
            if (sram_write_en)
                sram_mem[sram_write_addr] <= merge(sram_mem[sram_write_addr], sram_write_data, sram_write_byte_en);
            if (sram_read_en) sram_read_data <= sram_mem[sram_read_addr];
        end
    end

    // Reference model state.
    typedef struct {
        logic [DW-1:0] data;
        int            acc_cyc;
        bit            is_read;
    } exp_t;

    logic [DW-1:0] ref_mem [NE];
    exp_t          q0[$];
    exp_t          q1[$];
    int            grant_log[$];
    bit            busy_m;
    bit            prio_m;
    int            gcnt0, gcnt1;
    logic [DW-1:0] last0, last1;
    bit            seen0, seen1;
    int            rdy_mode0, rdy_mode1;   // 0 low, 1 high, 2 random

    // Response-ready drivers.
    initial begin
        resp0_rdy = 1'b0;
        resp1_rdy = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            resp0_rdy = (rdy_mode0 == 2) ? ($urandom_range(0, 3) != 0) : (rdy_mode0 == 1);
            resp1_rdy = (rdy_mode1 == 2) ? ($urandom_range(0, 3) != 0) : (rdy_mode1 == 1);
        end
    end

    // Acceptance monitor: arbitration and SRAM-port checks, pushes expected responses.
    bit            a0, a1, eg0, eg1, ere, ewe, at;
    logic [AW-1:0] aa;
    logic [DW-1:0] ad;
    logic [BW-1:0] ab;
    exp_t          ne;
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                busy_m = 0;
                prio_m = 0;
                gcnt0  = 0;
                gcnt1  = 0;
            end else begin
                a0 = req0_val && req0_rdy;
                a1 = req1_val && req1_rdy;
                if (req0_val || req1_val) begin
                    eg0 = !busy_m && req0_val && (!prio_m || !req1_val);
                    eg1 = !busy_m && req1_val && ( prio_m || !req0_val);
                    chk("req0_rdy", req0_rdy, eg0);
                    chk("req1_rdy", req1_rdy, eg1);
                end else begin
                    chk("rdy_without_req", {req0_rdy, req1_rdy}, 2'b00);
                end
                at  = a1 ? req1_type : req0_type;
                aa  = a1 ? req1_addr : req0_addr;
                ad  = a1 ? req1_data : req0_data;
                ab  = a1 ? req1_byte_en : req0_byte_en;
                ere = (a0 || a1) && !at;
                ewe = (a0 || a1) && at;
                chk("sram_read_en", sram_read_en, ere);
                chk("sram_write_en", sram_write_en, ewe);
                if (ere) chk("sram_read_addr", sram_read_addr, aa);
                else     chk("sram_read_addr_idle", sram_read_addr, 0);
                if (ewe) chk("sram_write_bus", {sram_write_addr, sram_write_data, sram_write_byte_en}, {aa, ad, ab});
                else     chk("sram_write_bus_idle", {sram_write_addr, sram_write_data, sram_write_byte_en}, 0);
                if (a0 || a1) begin
                    ne.acc_cyc = cyc;
                    ne.is_read = !at;
                    if (at) begin
                        ref_mem[aa] = merge(ref_mem[aa], ad, ab);
                        ne.data = '0;
                    end else begin
                        ne.data = ref_mem[aa];
                    end
                    if (a1) begin q1.push_back(ne); gcnt1 = (gcnt1 == 65535) ? gcnt1 : gcnt1 + 1; end
                    else    begin q0.push_back(ne); gcnt0 = (gcnt0 == 65535) ? gcnt0 : gcnt0 + 1; end
                    grant_log.push_back(a1 ? 1 : 0);
                    busy_m = 1;
                    prio_m = !a1;
                end
                if ((resp0_val && resp0_rdy) || (resp1_val && resp1_rdy)) busy_m = 0;
            end
        end
    end

    // Response monitor: pops expected entries on resp handshake, checks data and first-valid latency.
    exp_t e0, e1;
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (resp0_val) begin
                    if (q0.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL resp0_spurious: resp0_val=1 with no outstanding request (cycle %0d)", cyc);
                    end else begin
                        e0 = q0[0];
                        if (!seen0) begin
                            chk("resp0_latency", 64'(cyc - e0.acc_cyc), e0.is_read ? 2 : 1);
                            seen0 = 1;
                        end
                        chk("resp0_data", resp0_data, e0.data);
                        if (resp0_rdy) begin
                            void'(q0.pop_front());
                            seen0 = 0;
                            last0 = resp0_data;
                        end
                    end
                end
                if (resp1_val) begin
                    if (q1.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL resp1_spurious: resp1_val=1 with no outstanding request (cycle %0d)", cyc);
                    end else begin
                        e1 = q1[0];
                        if (!seen1) begin
                            chk("resp1_latency", 64'(cyc - e1.acc_cyc), e1.is_read ? 2 : 1);
                            seen1 = 1;
                        end
                        chk("resp1_data", resp1_data, e1.data);
                        if (resp1_rdy) begin
                            void'(q1.pop_front());
                            seen1 = 0;
                            last1 = resp1_data;
                        end
                    end
                end
            end
        end
    end

    // Present one request and hold it until accepted; returns 1 ns after the edge following acceptance.
    task automatic issue(input int p, input bit t, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [BW-1:0] be);
        bit done = 0;
        int n = 0;
        if (p == 0) begin
            req0_val = 1; req0_type = t; req0_addr = a; req0_data = d; req0_byte_en = be;
        end else begin
            req1_val = 1; req1_type = t; req1_addr = a; req1_data = d; req1_byte_en = be;
        end
        while (!done) begin
            @(negedge clk);
            if ((p == 0) ? req0_rdy : req1_rdy) done = 1;
            @(posedge clk);
            #1;
            n++;
            if (!done && n > 300) begin
                checks++; errors++;
                $display("FAIL req%0d_accept_timeout: not accepted within 300 cycles", p);
                done = 1;
            end
        end
        if (p == 0) req0_val = 0;
        else        req1_val = 0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0 || busy_m) && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 400) begin
            checks++; errors++;
            $display("FAIL drain_timeout: responses outstanding q0=%0d q1=%0d", q0.size(), q1.size());
        end
    endtask

    task automatic chk_counters();
`ifdef SRAM_ARB_GRANT_CNT_EN
        chk("grant_cnt0", grant_cnt0, gcnt0);
        chk("grant_cnt1", grant_cnt1, gcnt1);
`else
        chk("grant_cnt0_tied", grant_cnt0, 0);
        chk("grant_cnt1_tied", grant_cnt1, 0);
`endif
    endtask

    initial begin
        for (int i = 0; i < NE; i++) ref_mem[i] = init_word(i);
        seen0 = 0; seen1 = 0; busy_m = 0; prio_m = 0; gcnt0 = 0; gcnt1 = 0;
        last0 = '0; last1 = '0;
        rdy_mode0 = 1; rdy_mode1 = 1;
        mem_init = 1;
        rst = 1;
        req0_val = 1; req0_type = 0; req0_addr = 8'h01; req0_data = '0; req0_byte_en = '0;
        req1_val = 1; req1_type = 1; req1_addr = 8'h02; req1_data = '1; req1_byte_en = '1;

        // Reset state: every output low even with requests pending.
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ctrl_outs", {req0_rdy, req1_rdy, resp0_val, resp1_val, sram_read_en, sram_write_en}, 0);
        chk("reset_resp_data", {resp0_data, resp1_data}, 0);
        chk("reset_sram_bus", {sram_read_addr, sram_write_addr, sram_write_data, sram_write_byte_en}, 0);
        chk("reset_grant_cnt", {grant_cnt0, grant_cnt1}, 0);
        mem_init = 0;
        req0_val = 0; req1_val = 0;
        @(posedge clk);
        #1;
        rst = 0;

        // Both ports continuously requesting reads: grants alternate starting at port 0.
        grant_log.delete();
        fork
            for (int i = 0; i < 3; i++) issue(0, 0, 8'h01, '0, '0);
            for (int i = 0; i < 3; i++) issue(1, 0, 8'h02, '0, '0);
        join
        wait_drain();
        chk("grant_order0", grant_log[0], 0);
        chk("grant_order1", grant_log[1], 1);
        chk("grant_order2", grant_log[2], 0);
        chk("grant_order3", grant_log[3], 1);
        chk("alt_read0_data", last0, init_word(1));
        chk("alt_read1_data", last1, init_word(2));
        chk_counters();

        // Full write then read-back on port 0.
        issue(0, 1, 8'h05, 32'hDEADBEEF, 4'hF);
        issue(0, 0, 8'h05, '0, '0);
        wait_drain();
        chk("rdback_05", last0, 32'hDEADBEEF);

        // Partial byte write merges into the existing word.
        issue(0, 1, 8'h10, 32'h11223344, 4'hF);
        issue(0, 1, 8'h10, 32'h0000AB00, 4'b0010);
        issue(0, 0, 8'h10, '0, '0);
        wait_drain();
        chk("partial_write_10", last0, 32'h1122AB44);

        // Response held off for several cycles while port 1 waits.
        rdy_mode0 = 0;
        issue(0, 0, 8'h05, '0, '0);
        req1_val = 1; req1_type = 0; req1_addr = 8'h02; req1_data = '0; req1_byte_en = '0;
        @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_resp0_val", resp0_val, 1);
            chk("hold_resp0_data", resp0_data, 32'hDEADBEEF);
            chk("hold_no_grant", {req0_rdy, req1_rdy, sram_read_en, sram_write_en}, 0);
        end
        @(posedge clk);
        #1;
        rdy_mode0 = 1;
        @(posedge clk);
        @(negedge clk);
        chk("release_grant_port1", req1_rdy, 1);
        @(posedge clk);
        #1;
        req1_val = 0;
        wait_drain();

        // Reset while a read waits for SRAM data: outputs drop at once, nothing is returned.
        issue(0, 0, 8'h05, '0, '0);
        req0_val = 1; req1_val = 1;
        rst = 1;
        #1;
        chk("midreset_ctrl_outs", {req0_rdy, req1_rdy, resp0_val, resp1_val, sram_read_en, sram_write_en}, 0);
        chk("midreset_grant_cnt", {grant_cnt0, grant_cnt1}, 0);
        q0.delete(); q1.delete(); seen0 = 0; seen1 = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        @(negedge clk);
        chk("post_reset_grant_port0", {req0_rdy, req1_rdy}, 2'b10);
        @(posedge clk);
        #1;
        req0_val = 0; req1_val = 0;
        wait_drain();
        chk("post_reset_read_data", last0, 32'hDEADBEEF);
        chk_counters();

        // Random mixed traffic with random response backpressure.
        rdy_mode0 = 2; rdy_mode1 = 2;
        fork
            for (int i = 0; i < 120; i++) begin
                issue(0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 15)));
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
            end
            for (int i = 0; i < 120; i++) begin
                issue(1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 15)));
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
            end
        join
        rdy_mode0 = 1; rdy_mode1 = 1;
        wait_drain();
        chk_counters();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
